// File: rtl/radar_panel_ctrl.sv
// Front-panel controller: debounced mode/range buttons, operating-mode FSM, range sequencing.
// Button events appear 1 cycle after the debounced edge; FSM/range outputs update 1 cycle after an event.

module radar_panel_btn #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic short_evt,
  output logic long_evt
);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              sync_q1;
  logic              sync_q2;
  logic              stable;
  logic              stable_d;
  logic              long_flag;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      stable  <= 1'b1;
      deb_cnt <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (sync_q2 != stable) begin
        if (deb_cnt == DEB_MAX) begin
          stable  <= sync_q2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // long_flag is sampled before it clears, so the release after a long press stays silent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d  <= 1'b1;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
      long_flag <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      stable_d  <= stable;
      short_evt <= stable && !stable_d && !long_flag;
      long_evt  <= 1'b0;
      if (stable) begin
        hold_cnt  <= '0;
        long_flag <= 1'b0;
      end else if (hold_cnt == HOLD_MAX) begin
        if (!long_flag) begin
          long_evt  <= 1'b1;
          long_flag <= 1'b1;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

module radar_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int NUM_RANGES        = 4,
  localparam int RANGE_W          = $clog2(NUM_RANGES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_mode,
  input  logic               btn_range,
  input  logic               sweep_done,
  input  logic               cal_done,
  output logic [1:0]         mode_state,
  output logic               sweep_en,
  output logic               cal_start,
  output logic [RANGE_W-1:0] range_sel,
  output logic               range_pending
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_HOLD  = 2'd2,
    ST_CAL   = 2'd3
  } state_t;

  localparam logic [RANGE_W-1:0] RANGE_MAX = RANGE_W'(NUM_RANGES - 1);

  logic mode_short;
  logic mode_long;
  logic range_short;
  logic range_long;

  state_t             state;
  state_t             state_n;
  logic [RANGE_W-1:0] target;
  logic [RANGE_W-1:0] target_n;
  logic [RANGE_W-1:0] target_upd;
  logic [RANGE_W-1:0] range_sel_n;
  logic               range_pending_n;
  logic               sweep_en_n;
  logic               cal_start_n;

  radar_panel_btn #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_btn_mode (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn      (btn_mode),
    .short_evt(mode_short),
    .long_evt (mode_long)
  );

  radar_panel_btn #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_btn_range (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn      (btn_range),
    .short_evt(range_short),
    .long_evt (range_long)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      target        <= '0;
      range_sel     <= '0;
      range_pending <= 1'b0;
      sweep_en      <= 1'b0;
      cal_start     <= 1'b0;
    end else begin
      state         <= state_n;
      target        <= target_n;
      range_sel     <= range_sel_n;
      range_pending <= range_pending_n;
      sweep_en      <= sweep_en_n;
      cal_start     <= cal_start_n;
    end
  end

  always_comb begin
    target_upd = target;
    if (range_long) begin
      target_upd = '0;
    end else if (range_short) begin
      target_upd = (target == RANGE_MAX) ? '0 : target + 1'b1;
    end
  end

  // Range application is decided by the pre-transition state
  always_comb begin
    state_n         = state;
    target_n        = target;
    range_sel_n     = range_sel;
    range_pending_n = range_pending;
    if (state == ST_CAL) begin
      if (cal_done) begin
        state_n = ST_IDLE;
      end
    end else if (mode_long) begin
      state_n         = ST_CAL;
      target_n        = range_sel;
      range_pending_n = 1'b0;
    end else begin
      if (mode_short) begin
        case (state)
          ST_IDLE:  state_n = ST_SWEEP;
          ST_SWEEP: state_n = ST_HOLD;
          default:  state_n = ST_SWEEP;
        endcase
      end
      target_n = target_upd;
      if (state == ST_SWEEP) begin
        if (sweep_done || mode_short) begin
          range_sel_n     = target_upd;
          range_pending_n = 1'b0;
        end else if (range_short || range_long) begin
          range_pending_n = 1'b1;
        end
      end else begin
        range_sel_n     = target_upd;
        range_pending_n = 1'b0;
      end
    end
  end

  always_comb begin
    sweep_en_n  = (state_n == ST_SWEEP);
    cal_start_n = (state_n == ST_CAL) && (state != ST_CAL);
  end

  assign mode_state = state;
endmodule

// File: tb/tb_radar_panel_ctrl.sv
// Directed bench for radar_panel_ctrl with short debounce/long-press parameters.
module tb_radar_panel_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_mode = 1'b1;
  logic       btn_range = 1'b1;
  logic       sweep_done = 1'b0;
  logic       cal_done = 1'b0;
  logic [1:0] mode_state;
  logic       sweep_en;
  logic       cal_start;
  logic [1:0] range_sel;
  logic       range_pending;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  radar_panel_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .NUM_RANGES       (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_mode     (btn_mode),
    .btn_range    (btn_range),
    .sweep_done   (sweep_done),
    .cal_done     (cal_done),
    .mode_state   (mode_state),
    .sweep_en     (sweep_en),
    .cal_start    (cal_start),
    .range_sel    (range_sel),
    .range_pending(range_pending)
  );

  // op: 0 = press buttons (mlen/rlen low cycles, 0 = untouched), 1 = sweep_done pulse, 2 = cal_done pulse
  typedef struct {
    int         op;
    int         mlen;
    int         rlen;
    logic [1:0] st;
    logic       en;
    logic [1:0] sel;
    logic       pd;
  } vec_t;

  vec_t tbl[20];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input logic en, input logic cs,
                     input logic [1:0] sel, input logic pd);
    n_vec++;
    if (mode_state !== st || sweep_en !== en || cal_start !== cs || range_sel !== sel ||
        range_pending !== pd) begin
      n_bad++;
      $display("FAIL %s: got state=%0d en=%b cs=%b sel=%0d pend=%b, want state=%0d en=%b cs=%b sel=%0d pend=%b",
               nm, mode_state, sweep_en, cal_start, range_sel, range_pending, st, en, cs, sel, pd);
    end
  endtask

  task automatic press(input int ml, input int rl);
    int mx;
    mx = (ml > rl) ? ml : rl;
    btn_mode  = (ml == 0);
    btn_range = (rl == 0);
    for (int c = 1; c <= mx; c++) begin
      tick(1);
      btn_mode  = (c >= ml);
      btn_range = (c >= rl);
    end
    tick(12);
  endtask

  task automatic apply(input int idx);
    case (tbl[idx].op)
      1: begin
        sweep_done = 1'b1;
        tick(1);
        sweep_done = 1'b0;
        tick(12);
      end
      2: begin
        cal_done = 1'b1;
        tick(1);
        cal_done = 1'b0;
        tick(12);
      end
      default: press(tbl[idx].mlen, tbl[idx].rlen);
    endcase
    chk($sformatf("vec%0d", idx), tbl[idx].st, tbl[idx].en, 1'b0, tbl[idx].sel, tbl[idx].pd);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 5, 2'd0, 1'b0, 2'd1, 1'b0};
    tbl[1]  = '{0, 0, 5, 2'd0, 1'b0, 2'd2, 1'b0};
    tbl[2]  = '{0, 0, 5, 2'd0, 1'b0, 2'd3, 1'b0};
    tbl[3]  = '{0, 0, 5, 2'd0, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{0, 10, 0, 2'd1, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{0, 5, 0, 2'd2, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{0, 5, 0, 2'd1, 1'b1, 2'd0, 1'b0};
    tbl[7]  = '{0, 0, 5, 2'd1, 1'b1, 2'd0, 1'b1};
    tbl[8]  = '{0, 0, 5, 2'd1, 1'b1, 2'd0, 1'b1};
    tbl[9]  = '{1, 0, 0, 2'd1, 1'b1, 2'd2, 1'b0};
    tbl[10] = '{0, 0, 5, 2'd1, 1'b1, 2'd2, 1'b1};
    tbl[11] = '{0, 0, 5, 2'd3, 1'b0, 2'd2, 1'b0};
    tbl[12] = '{0, 5, 0, 2'd3, 1'b0, 2'd2, 1'b0};
    tbl[13] = '{2, 0, 0, 2'd0, 1'b0, 2'd2, 1'b0};
    tbl[14] = '{0, 0, 5, 2'd0, 1'b0, 2'd3, 1'b0};
    tbl[15] = '{0, 0, 25, 2'd0, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{0, 0, 5, 2'd0, 1'b0, 2'd1, 1'b0};
    tbl[17] = '{0, 10, 0, 2'd1, 1'b1, 2'd1, 1'b0};
    tbl[18] = '{0, 5, 5, 2'd2, 1'b0, 2'd2, 1'b0};
    tbl[19] = '{1, 0, 0, 2'd2, 1'b0, 2'd2, 1'b0};

    tick(3);
    chk("reset_state", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    tick(2);

    for (int k = 0; k < 5; k++) begin
      btn_mode = 1'b0;
      tick(3);
      btn_mode = 1'b1;
      tick(3);
    end
    tick(12);
    chk("bounce_reject", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i <= 10; i++) apply(i);

    // Long mode press from SWEEP with a queued range change (target 3, sel 2)
    btn_mode = 1'b0;
    tick(26);
    chk("long_before_threshold", 2'd1, 1'b1, 1'b0, 2'd2, 1'b1);
    tick(1);
    chk("long_cal_entry", 2'd3, 1'b0, 1'b1, 2'd2, 1'b0);
    tick(1);
    chk("long_cal_start_pulse", 2'd3, 1'b0, 1'b0, 2'd2, 1'b0);
    tick(12);
    btn_mode = 1'b1;
    tick(15);
    chk("long_release", 2'd3, 1'b0, 1'b0, 2'd2, 1'b0);

    for (int i = 11; i < 20; i++) apply(i);

    // Reset asserted mid-press, button still held after release
    btn_range = 1'b0;
    tick(15);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_press", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(8);
    chk("held_through_reset", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    btn_range = 1'b1;
    tick(12);
    chk("press_after_reset", 2'd0, 1'b0, 1'b0, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/radar_panel_ctrl.md
Name: radar_panel_ctrl

Overview:
Front-panel controller for the radar. It debounces two active-low push buttons (mode, range) and classifies each press as short or long. It then runs the operating-mode FSM (IDLE/SWEEP/HOLD/CAL) that gates the sweep datapath and starts calibration. It also sequences range-select changes so they land only on sweep boundaries.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized input must differ from its stable level before the stable level flips (10 ms at 50 MHz); must be >= 2.
LONG_PRESS_CYCLES, 50000000, cycles the stable level must stay low to count as a long press (1 s); must be > DEBOUNCE_CYCLES.
NUM_RANGES, 4, number of range settings; must be >= 2; RANGE_W = $clog2(NUM_RANGES).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_mode  input  1  raw mode button, active-low, asynchronous to clk
btn_range  input  1  raw range button, active-low, asynchronous to clk
sweep_done  input  1  one-cycle pulse from sweep logic at end of each sweep
cal_done  input  1  one-cycle pulse from calibration logic
mode_state  output  2  0=IDLE, 1=SWEEP, 2=HOLD, 3=CAL
sweep_en  output  1  high exactly while mode_state==SWEEP
cal_start  output  1  one-cycle pulse on entry to CAL
range_sel  output  RANGE_W  active range setting
range_pending  output  1  a range change is queued for the next sweep boundary

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low. All state resets asynchronously.
- Reset values:
  - mode_state=IDLE, sweep_en=0, cal_start=0, range_sel=0, range_pending=0, internal target=0.
  - Synchronizer flops and stable levels reset to 1 (released); all counters reset to 0.
- Per-button front end (identical for both buttons):
  - Synchronizer: two-flop synchronizer.
  - Debounce counter:
    - Increments each cycle the synchronized value != stable level.
    - Clears the first cycle they are equal.
    - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes the synchronized value at that edge and the counter clears.
  - Hold counter:
    - Counts while stable==0; clears on stable==1.
    - When it reaches LONG_PRESS_CYCLES-1, a one-cycle long_evt fires and a per-press long flag sets.
    - The counter then saturates; no repeat events.
  - Short press: on the rising edge of stable, a one-cycle short_evt fires only if the long flag is clear. The long flag clears on release.
  - Event timing: events are registered and appear the cycle after the stable transition or threshold.
- Mode FSM: acts on events at the edge following the event cycle; outputs are registered with the state.
  - IDLE: mode short -> SWEEP.
  - SWEEP: mode short -> HOLD.
  - HOLD: mode short -> SWEEP.
  - IDLE/SWEEP/HOLD: mode long -> CAL. cal_start=1 for exactly the entry cycle; sweep_en=0.
  - CAL: all button events ignored; cal_done -> IDLE. sweep_done is ignored outside SWEEP.
- Range sequencing:
  - Range short increments target modulo NUM_RANGES ((NUM_RANGES-1) -> 0). Range long sets target=0.
  - In IDLE or HOLD, range_sel<=target at the same edge; range_pending stays 0.
  - In SWEEP, target updates but range_sel holds; range_pending=1.
  - On sweep_done in SWEEP, or on the SWEEP->HOLD transition: range_sel<=target, range_pending<=0.
  - Entering CAL: target<=range_sel and range_pending<=0 (queued change dropped). Range events in CAL are ignored.
- Simultaneous events:
  - A mode event and a range event in the same cycle are both processed. The FSM transition decides whether the range event applies immediately or queues, using the current (pre-transition) state.
  - SWEEP->HOLD in the same cycle as a range short applies the incremented target immediately.
  - sweep_done coinciding with a mode short in SWEEP: transition to HOLD and apply target.
  - cal_done coinciding with anything in CAL: -> IDLE; button events that cycle are ignored.
- Reset mid-press: all press history is discarded. A button held through reset release is seen as a new press after the full debounce interval.

Test Plan:
Use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_RANGES=4.
1. Bounce rejection: btn_mode toggles low 3 cycles / high 3 cycles x5 -> no event, mode_state stays 0. Then low 10 cycles and release -> mode_state=1, sweep_en=1 after the debounced rising edge plus event and state latency; no long event.
2. Mode cycling: short presses from SWEEP -> mode_state 2, sweep_en=0; next short -> 1. Check sweep_en tracks state exactly.
3. Range queueing: in IDLE, 3 shorts -> range_sel 1,2,3; a 4th -> 0 (wrap). Enter SWEEP, 2 shorts -> range_sel=0, range_pending=1. Pulse sweep_done -> range_sel=2, range_pending=0 the next cycle.
4. Long press to CAL from SWEEP with range_pending=1: hold btn_mode low 40 cycles -> CAL exactly when the hold threshold fires; cal_start high 1 cycle; range_pending=0; release gives no short. Range/mode presses in CAL -> no change. cal_done -> mode_state=0.
5. Simultaneous: in SWEEP with range_sel=1, mode short and range short events in the same cycle -> mode_state=2, range_sel=2, range_pending=0.
6. Reset mid-press: btn_range held low, pulse reset_n low mid-hold -> all outputs at reset values immediately. With the button still held after release, no event before the debounce interval; release after 8 cycles -> range_sel=1.
